// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the data-memory responder.
//   Store size codes, MMIO register offsets (relative to MMIO_BASE)
//   and the bit positions of the STATUS register.
package dmem_pkg;

    localparam logic [1:0] ST_B    = 2'b00;
    localparam logic [1:0] ST_H    = 2'b01;
    localparam logic [1:0] ST_W    = 2'b10;
    localparam logic [1:0] ST_NONE = 2'b11;

    localparam logic [31:0] OFS_TXDATA = 32'h0000_0000;
    localparam logic [31:0] OFS_STATUS = 32'h0000_0004;
    localparam logic [31:0] OFS_CYCLE  = 32'h0000_0008;

    localparam int STAT_EMPTY    = 0;
    localparam int STAT_FULL     = 1;
    localparam int STAT_OVERFLOW = 2;
    localparam int STAT_MISALIGN = 3;

endpackage

// File: rtl/tx_byte_fifo.sv
// tx_byte_fifo: byte FIFO for the MMIO transmit path.
//   clk, reset (async, active-low)
//   push/din : write din when push && !full
//   pop      : drop head when pop && !empty
//   dout     : head byte (0 while empty)
//   full, empty
// Pointers carry one extra wrap bit so full/empty need no counter.
module tx_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
            if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; dout is masked while empty instead.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the core's data port.
//   clk, reset (async, active-low)
//   MemWrite, Mem_WrAddr, Mem_WrData, Store : store interface from the core
//   ReadData : combinational aligned word at Mem_WrAddr
//   tx_data, tx_valid, tx_ready : TX FIFO drain port
//   mem_err  : sticky misalign | overflow
// Addresses below MMIO_BASE hit word RAM; above it sit TXDATA, STATUS, CYCLE.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_0400,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Mem_WrAddr,
    input  logic [31:0] Mem_WrData,
    input  logic [1:0]  Store,
    output logic [31:0] ReadData,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        mem_err
);
    localparam int IW = $clog2(DEPTH_WORDS);

    logic [31:0]   ram [DEPTH_WORDS];
    logic [31:0]   cycle_cnt;
    logic          misalign, overflow;
    logic          fifo_full, fifo_empty;

    logic          is_ram;
    logic [31:0]   mofs;
    logic [IW-1:0] widx;
    logic          st_ok;
    logic          hit_tx, hit_status, hit_cycle;
    logic [3:0]    be;
    logic [31:0]   wdat;
    logic          mis_now;
    logic          ram_we, push_req, pop, set_mis, set_ovf, clr_flags;

    assign is_ram = (Mem_WrAddr < MMIO_BASE);
    assign mofs   = Mem_WrAddr - MMIO_BASE;
    assign widx   = Mem_WrAddr[IW+1:2];
    assign st_ok  = MemWrite && (Store != ST_NONE);

    // MMIO registers decode on the word; the byte offset is ignored.
    assign hit_tx     = !is_ram && ((mofs & ~32'h3) == OFS_TXDATA);
    assign hit_status = !is_ram && ((mofs & ~32'h3) == OFS_STATUS);
    assign hit_cycle  = !is_ram && ((mofs & ~32'h3) == OFS_CYCLE);

    // Lane enables and lane-replicated store data for RAM writes.
    always_comb begin
        be      = 4'b0000;
        wdat    = Mem_WrData;
        mis_now = 1'b0;
        case (Store)
            ST_B: begin
                be   = 4'b0001 << Mem_WrAddr[1:0];
                wdat = {4{Mem_WrData[7:0]}};
            end
            ST_H: begin
                wdat = {2{Mem_WrData[15:0]}};
                if (Mem_WrAddr[0]) mis_now = 1'b1;
                else               be = Mem_WrAddr[1] ? 4'b1100 : 4'b0011;
            end
            ST_W: begin
                if (Mem_WrAddr[1:0] != 2'b00) mis_now = 1'b1;
                else                          be = 4'b1111;
            end
            default: ;
        endcase
    end

    assign ram_we    = st_ok && is_ram && !mis_now;
    assign set_mis   = st_ok && is_ram && mis_now;
    assign push_req  = st_ok && hit_tx;
    assign set_ovf   = push_req && fifo_full;   // full judged before any same-edge pop
    assign clr_flags = st_ok && hit_status;
    assign pop       = tx_valid && tx_ready;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) ram[widx][8*i +: 8] <= wdat[8*i +: 8];
        end
    end

    // Set beats clear when both land on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign  <= 1'b0;
            overflow  <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            if (set_mis)        misalign <= 1'b1;
            else if (clr_flags) misalign <= 1'b0;
            if (set_ovf)        overflow <= 1'b1;
            else if (clr_flags) overflow <= 1'b0;
            cycle_cnt <= (st_ok && hit_cycle) ? 32'h0 : cycle_cnt + 32'h1;
        end
    end

    tx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .din   (Mem_WrData[7:0]),
        .pop   (pop),
        .dout  (tx_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tx_valid = !fifo_empty;
    assign mem_err  = misalign | overflow;

    always_comb begin
        ReadData = 32'h0;
        if (is_ram) begin
            ReadData = ram[widx];
        end else if (hit_status) begin
            ReadData[STAT_EMPTY]    = fifo_empty;
            ReadData[STAT_FULL]     = fifo_full;
            ReadData[STAT_OVERFLOW] = overflow;
            ReadData[STAT_MISALIGN] = misalign;
        end else if (hit_cycle) begin
            ReadData = cycle_cnt;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam logic [31:0] A_TX  = 32'h0000_0400;
    localparam logic [31:0] A_ST  = 32'h0000_0404;
    localparam logic [31:0] A_CYC = 32'h0000_0408;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Mem_WrAddr = 32'h0;
    logic [31:0] Mem_WrData = 32'h0;
    logic [1:0]  Store = ST_NONE;
    logic [31:0] ReadData;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        mem_err;

    int errors = 0;
    int checks = 0;

    dmem_responder dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .Mem_WrAddr(Mem_WrAddr),
        .Mem_WrData(Mem_WrData), .Store(Store), .ReadData(ReadData),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        @(negedge clk);
        MemWrite = 1'b1; Mem_WrAddr = a; Mem_WrData = d; Store = s;
        @(posedge clk);
        #1 MemWrite = 1'b0; Store = ST_NONE;
    endtask

    task automatic rd(input logic [31:0] a);
        Mem_WrAddr = a;
        #1;
    endtask

    task automatic test_reset;
        #3;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL rst_mem_err: got %b want 0", mem_err); end
        rd(A_ST);
        checks++; if (ReadData !== 32'h1) begin errors++; $display("FAIL rst_status: got %h want 00000001", ReadData); end
        rd(A_CYC);
        checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL rst_cycle: got %h want 00000000", ReadData); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_ram_lanes;
        do_store(32'h10, 32'hDEADBEEF, ST_W);
        rd(32'h10);
        checks++; if (ReadData !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_sw: got %h want DEADBEEF", ReadData); end
        do_store(32'h11, 32'hFFFF_FFAA, ST_B);
        rd(32'h13);
        checks++; if (ReadData !== 32'hDEADAAEF) begin errors++; $display("FAIL ram_sb: got %h want DEADAAEF", ReadData); end
        do_store(32'h12, 32'hFFFF_1234, ST_H);
        rd(32'h10);
        checks++; if (ReadData !== 32'h1234AAEF) begin errors++; $display("FAIL ram_sh: got %h want 1234AAEF", ReadData); end
        do_store(32'h14, 32'h5566_7788, ST_NONE);
        rd(32'h10);
        checks++; if (ReadData !== 32'h1234AAEF) begin errors++; $display("FAIL ram_nostore: got %h want 1234AAEF", ReadData); end
        rd(A_ST);
        checks++; if (ReadData !== 32'h1) begin errors++; $display("FAIL ram_status_clean: got %h want 00000001", ReadData); end
    endtask

    task automatic test_misalign;
        do_store(32'h20, 32'h1111_1111, ST_W);
        do_store(32'h21, 32'h0000_2222, ST_H);
        do_store(32'h22, 32'h3333_3333, ST_W);
        rd(32'h20);
        checks++; if (ReadData !== 32'h1111_1111) begin errors++; $display("FAIL mis_ram: got %h want 11111111", ReadData); end
        rd(A_ST);
        checks++; if (ReadData !== 32'h9) begin errors++; $display("FAIL mis_status: got %h want 00000009", ReadData); end
        checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL mis_mem_err: got %b want 1", mem_err); end
        do_store(A_ST, 32'h0, ST_W);
        rd(A_ST);
        checks++; if (ReadData !== 32'h1) begin errors++; $display("FAIL mis_clear: got %h want 00000001", ReadData); end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL mis_clear_err: got %b want 0", mem_err); end
    endtask

    task automatic test_overflow_drain;
        do_store(A_TX, 32'h41, ST_B);
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin errors++; $display("FAIL tx_first: got v=%b d=%h want v=1 d=41", tx_valid, tx_data); end
        for (int i = 1; i < 5; i++) do_store(A_TX + 32'(i % 4), 32'h41 + 32'(i), ST_B);
        rd(A_ST);
        checks++; if (ReadData !== 32'h6) begin errors++; $display("FAIL ovf_status: got %h want 00000006", ReadData); end
        checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL ovf_mem_err: got %b want 1", mem_err); end
        rd(A_TX);
        checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL txdata_read: got %h want 00000000", ReadData); end
        @(negedge clk);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin errors++; $display("FAIL drain_%0d: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, 8'(8'h41 + i)); end
            @(negedge clk);
        end
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", tx_valid); end
        tx_ready = 1'b0;
        do_store(A_ST, 32'h0, ST_B);
        rd(A_ST);
        checks++; if (ReadData !== 32'h1) begin errors++; $display("FAIL ovf_clear: got %h want 00000001", ReadData); end
    endtask

    task automatic test_back_to_back;
        do_store(A_TX, 32'h50, ST_B);
        do_store(A_TX, 32'h51, ST_W);
        @(negedge clk);
        MemWrite = 1'b1; Mem_WrAddr = A_TX; Mem_WrData = 32'h52; Store = ST_B; tx_ready = 1'b1;
        @(posedge clk);
        #1 MemWrite = 1'b0; Store = ST_NONE; tx_ready = 1'b0;
        rd(A_ST);
        checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL pp_status: got %h want 00000000", ReadData); end
        checks++; if (tx_data !== 8'h51) begin errors++; $display("FAIL pp_head: got %h want 51", tx_data); end
        @(negedge clk);
        tx_ready = 1'b1;
        #1;
        checks++; if (tx_data !== 8'h51) begin errors++; $display("FAIL pp_d0: got %h want 51", tx_data); end
        @(negedge clk); #1;
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h52) begin errors++; $display("FAIL pp_d1: got v=%b d=%h want v=1 d=52", tx_valid, tx_data); end
        @(negedge clk); #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL pp_empty: got %b want 0", tx_valid); end
        tx_ready = 1'b0;
        // full FIFO with push and pop together: pop completes, push dropped
        for (int i = 0; i < 4; i++) do_store(A_TX, 32'h60 + 32'(i), ST_B);
        rd(A_ST);
        checks++; if (ReadData !== 32'h2) begin errors++; $display("FAIL full_status: got %h want 00000002", ReadData); end
        @(negedge clk);
        MemWrite = 1'b1; Mem_WrAddr = A_TX; Mem_WrData = 32'h64; Store = ST_B; tx_ready = 1'b1;
        @(posedge clk);
        #1 MemWrite = 1'b0; Store = ST_NONE;
        rd(A_ST);
        checks++; if (ReadData !== 32'h4) begin errors++; $display("FAIL fpp_status: got %h want 00000004", ReadData); end
        checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL fpp_mem_err: got %b want 1", mem_err); end
        @(negedge clk);
        for (int i = 1; i < 4; i++) begin
            #1;
            checks++; if (tx_valid !== 1'b1 || tx_data !== 8'(8'h60 + i)) begin errors++; $display("FAIL fpp_d%0d: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, 8'(8'h60 + i)); end
            @(negedge clk);
        end
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty: got %b want 0", tx_valid); end
        tx_ready = 1'b0;
        do_store(A_ST, 32'h0, ST_H);
    endtask

    task automatic test_cycle;
        do_store(A_CYC, 32'h1234, ST_W);
        rd(A_CYC);
        checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL cyc_load: got %h want 00000000", ReadData); end
        repeat (10) @(posedge clk);
        @(negedge clk);
        rd(A_CYC);
        checks++; if (ReadData !== 32'd10) begin errors++; $display("FAIL cyc_10: got %0d want 10", ReadData); end
        rd(32'h0000_040C);
        checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL unmapped: got %h want 00000000", ReadData); end
        @(negedge clk);
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        #1 release dut.cycle_cnt;
        rd(A_CYC);
        checks++; if (ReadData !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cyc_max: got %h want FFFFFFFF", ReadData); end
        @(posedge clk); #1;
        checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL cyc_wrap: got %h want 00000000", ReadData); end
    endtask

    task automatic test_reset_mid;
        do_store(A_TX, 32'h77, ST_B);
        do_store(32'h21, 32'h0, ST_H);
        checks++; if (tx_valid !== 1'b1 || mem_err !== 1'b1) begin errors++; $display("FAIL pre_rst: got v=%b e=%b want v=1 e=1", tx_valid, mem_err); end
        #2 reset = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0 || mem_err !== 1'b0) begin errors++; $display("FAIL mid_rst: got v=%b e=%b want v=0 e=0", tx_valid, mem_err); end
        rd(A_ST);
        checks++; if (ReadData !== 32'h1) begin errors++; $display("FAIL mid_rst_status: got %h want 00000001", ReadData); end
        rd(A_CYC);
        checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL mid_rst_cycle: got %h want 00000000", ReadData); end
        @(negedge clk);
        reset = 1'b1;
        rd(32'h10);
        checks++; if (ReadData !== 32'h1234AAEF) begin errors++; $display("FAIL ram_retained: got %h want 1234AAEF", ReadData); end
    endtask

    initial begin
        test_reset;
        test_ram_lanes;
        test_misalign;
        test_overflow_drain;
        test_back_to_back;
        test_cycle;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
